// File: rtl/secded_pkg.sv
// Shared types and constants for the Hamming (16,11) SECDED decode engine.
package secded_pkg;

  localparam int CW_W   = 16;
  localparam int MSG_W  = 11;
  localparam int DED_BIT = 15;

  // Syndrome bit j is the parity of every codeword position whose index has bit j set.
  localparam logic [CW_W-1:0] SYN_MASK [4] = '{16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00};

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/secded_decode_comb.sv
// Combinational SECDED decode of one 16-bit codeword into the result word
// {DED, 4'b0, d11..d1}. A p0-only error counts as a correction with no data change.
module secded_decode_comb
  import secded_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output logic [CW_W-1:0] result_o,
  output logic            sec_o,
  output logic            ded_o
);

  logic [3:0]      syn;
  logic            q;
  logic [CW_W-1:0] fixed;
  logic            unused_par_bits;

  // Syndrome from the four position-group parities.
  always_comb begin
    syn = '0;
    for (int j = 0; j < 4; j++) begin
      syn[j] = ^(cw_i & SYN_MASK[j]);
    end
  end

  assign q     = ^cw_i;
  assign sec_o = q;
  assign ded_o = (syn != 4'd0) && !q;

  // Flip the erroneous position on a single error; syndrome 0 means only p0 was hit.
  always_comb begin
    fixed = cw_i;
    if (q && (syn != 4'd0)) begin
      fixed[syn] = ~cw_i[syn];
    end
  end

  // Parity positions 0,1,2,4,8 carry no message data.
  assign unused_par_bits = ^{fixed[8], fixed[4], fixed[2:0]};

  assign result_o = {ded_o, 4'b0000, fixed[15:9], fixed[7:5], fixed[3]};

endmodule

// File: rtl/secded_decode_engine.sv
// SECDED decode engine: reads NUM_WORDS codewords from byte memory, writes the
// corrected 11-bit messages (with DED flag) back, counts SEC/DED events, pulses ack.
//
// state | meaning
// IDLE  | waiting for req; counts hold their last-run values
// RD_LO | read codeword low byte at SRC_BASE+2i
// RD_HI | read codeword high byte at SRC_BASE+2i+1
// WR_LO | write result low byte at DST_BASE+2i, update counts
// WR_HI | write result high byte at DST_BASE+2i+1, advance or finish
// DONE  | one-cycle ack
module secded_decode_engine
  import secded_pkg::*;
#(
  parameter int AW        = 8,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 94,
  parameter int NUM_WORDS = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [7:0]    sec_count,
  output logic [7:0]    ded_count
);

  localparam int IDX_W = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      sec_q, sec_d;
  logic [7:0]      ded_q, ded_d;

  logic [CW_W-1:0] result;
  logic            dec_sec;
  logic            dec_ded;
  logic [AW-1:0]   src_lo, src_hi, dst_lo, dst_hi;

  secded_decode_comb u_dec (
    .cw_i     ({hi_q, lo_q}),
    .result_o (result),
    .sec_o    (dec_sec),
    .ded_o    (dec_ded)
  );

  // Addresses wrap naturally at AW bits.
  assign src_lo = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
  assign src_hi = src_lo + AW'(1);
  assign dst_lo = AW'(DST_BASE) + AW'({idx_q, 1'b0});
  assign dst_hi = dst_lo + AW'(1);

  assign sec_count = sec_q;
  assign ded_count = ded_q;

  // State, index, latched codeword bytes and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      sec_q   <= '0;
      ded_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
    end
  end

  // Next-state logic and memory/handshake outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sec_d       = sec_q;
    ded_d       = ded_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    ack         = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RD_LO;
          idx_d   = '0;
          sec_d   = '0;
          ded_d   = '0;
        end
      end
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_lo;
        lo_d     = mem_rd_data;
        state_d  = RD_HI;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_hi;
        hi_d     = mem_rd_data;
        state_d  = WR_LO;
      end
      WR_LO: begin
        busy        = 1'b1;
        mem_addr    = dst_lo;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[7:0];
        if (dec_sec && (sec_q != 8'hFF)) sec_d = sec_q + 8'd1;
        if (dec_ded && (ded_q != 8'hFF)) ded_d = ded_q + 8'd1;
        state_d = WR_HI;
      end
      WR_HI: begin
        busy        = 1'b1;
        mem_addr    = dst_hi;
        mem_wr_en   = 1'b1;
        mem_wr_data = result[15:8];
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_LO;
        end
      end
      DONE: begin
        busy    = 1'b1;
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_secded_decode_engine.sv
// Bench for secded_decode_engine: directed single-word cases on a NUM_WORDS=1
// instance, randomized full runs, mid-run reset and req-while-busy on a default instance.
module tb_secded_decode_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic req1, req15;
  logic ack1, busy1, we1, ack15, busy15, we15;
  logic [7:0] addr1, addr15, rd1, rd15, wd1, wd15;
  logic [7:0] sec1, ded1, sec15, ded15;

  logic [7:0] mem1 [256];
  logic [7:0] mem15 [256];
  logic [7:0] img [256];
  logic ld1 = 1'b0, ld15 = 1'b0;

  int nvec = 0;
  int nfail = 0;

  int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic [15:0] exp_res [15];
  int exp_sec, exp_ded;

  secded_decode_engine #(.AW(8), .SRC_BASE(64), .DST_BASE(94), .NUM_WORDS(1)) u1 (
    .clk(clk), .reset(reset), .req(req1), .ack(ack1), .busy(busy1),
    .mem_addr(addr1), .mem_rd_data(rd1), .mem_wr_en(we1), .mem_wr_data(wd1),
    .sec_count(sec1), .ded_count(ded1));

  secded_decode_engine u15 (
    .clk(clk), .reset(reset), .req(req15), .ack(ack15), .busy(busy15),
    .mem_addr(addr15), .mem_rd_data(rd15), .mem_wr_en(we15), .mem_wr_data(wd15),
    .sec_count(sec15), .ded_count(ded15));

  assign rd1  = mem1[addr1];
  assign rd15 = mem15[addr15];

  // Byte memories: bulk preload from img, DUT writes at the rising edge.
  always @(posedge clk) begin
    if (ld1) for (int a = 0; a < 256; a++) mem1[a] = img[a];
    if (we1) mem1[addr1] = wd1;
  end
  always @(posedge clk) begin
    if (ld15) for (int a = 0; a < 256; a++) mem15[a] = img[a];
    if (we15) mem15[addr15] = wd15;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: place data bits, then even parity over each position group, then overall parity.
  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] c;
    logic p;
    c = '0;
    for (int i = 0; i < 11; i++) c[dpos[i]] = m[i];
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++)
        if (((k >> j) & 1) == 1 && k != (1 << j)) p ^= c[k];
      c[1 << j] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] m;
    for (int i = 0; i < 11; i++) m[i] = c[dpos[i]];
    return m;
  endfunction

  task automatic load1();
    @(negedge clk) ld1 = 1'b1;
    @(negedge clk) ld1 = 1'b0;
  endtask

  task automatic load15();
    @(negedge clk) ld15 = 1'b1;
    @(negedge clk) ld15 = 1'b0;
  endtask

  // Fresh random codewords with known 0/1/2-bit corruption; expectation follows from the corruption count.
  task automatic prep15();
    logic [10:0] m;
    logic [15:0] cw;
    int nflip, b1, b2;
    exp_sec = 0;
    exp_ded = 0;
    for (int i = 0; i < 15; i++) begin
      m     = 11'($urandom);
      cw    = encode(m);
      nflip = $urandom_range(0, 2);
      b1    = $urandom_range(0, 15);
      b2    = (b1 + $urandom_range(1, 15)) % 16;
      if (nflip >= 1) cw[b1] = ~cw[b1];
      if (nflip == 2) cw[b2] = ~cw[b2];
      if (nflip == 0) exp_res[i] = {5'b0, m};
      else if (nflip == 1) begin
        exp_res[i] = {5'b0, m};
        exp_sec++;
      end else begin
        exp_res[i] = {1'b1, 4'b0, extract(cw)};
        exp_ded++;
      end
      img[64 + 2*i] = cw[7:0];
      img[65 + 2*i] = cw[15:8];
      img[94 + 2*i] = 8'hAA;
      img[95 + 2*i] = 8'hAA;
    end
    load15();
  endtask

  task automatic check_words15(input string tag);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s_word%0d", tag, i), {mem15[95 + 2*i], mem15[94 + 2*i]}, exp_res[i]);
  endtask

  task automatic run1(output int first, output int nacks, output int busy_c1);
    @(negedge clk) req1 = 1'b1;
    @(posedge clk) #1;
    req1 = 1'b0;
    first = -1;
    nacks = 0;
    busy_c1 = busy1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (ack1) begin
        nacks++;
        if (first < 0) first = cyc;
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic run15(input int pulse_at, input bit hold, input int ncyc,
                       output int first, output int second, output int nacks, output int nwr);
    @(negedge clk) req15 = 1'b1;
    @(posedge clk) #1;
    if (!hold) req15 = 1'b0;
    first = -1;
    second = -1;
    nacks = 0;
    nwr = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (we15) nwr++;
      if (ack15) begin
        nacks++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (pulse_at > 0 && cyc == pulse_at) req15 = 1'b1;
      if (pulse_at > 0 && cyc == pulse_at + 1) req15 = 1'b0;
      if (hold && cyc == 63) req15 = 1'b0;
      @(posedge clk) #1;
    end
  endtask

  task automatic u1_case(input string tag, input logic [15:0] cw, input logic [15:0] exp,
                         input int es, input int ed);
    int first, nacks, bc1;
    img[64] = cw[7:0];
    img[65] = cw[15:8];
    img[94] = 8'h55;
    img[95] = 8'h55;
    load1();
    run1(first, nacks, bc1);
    check({tag, "_ack_cycle"}, first, 5);
    check({tag, "_ack_count"}, nacks, 1);
    check({tag, "_busy_c1"}, bc1, 1);
    check({tag, "_result"}, {mem1[95], mem1[94]}, exp);
    check({tag, "_sec"}, sec1, es);
    check({tag, "_ded"}, ded1, ed);
  endtask

  initial begin
    int first, second, nacks, nwr, wl, cyc;
    reset = 1'b0;
    req1  = 1'b0;
    req15 = 1'b0;
    for (int a = 0; a < 256; a++) img[a] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack15, 0);
    check("rst_busy", busy15, 0);
    check("rst_wr_en", we15, 0);
    check("rst_addr", addr15, 0);
    check("rst_wr_data", wd15, 0);
    check("rst_sec", sec15, 0);
    check("rst_ded", ded15, 0);
    @(negedge clk) reset = 1'b1;

    u1_case("clean",  16'hFFFF, 16'h07FF, 0, 0);
    u1_case("sec_b5", 16'hFFDF, 16'h07FF, 1, 0);
    u1_case("sec_p0", 16'hFFFE, 16'h07FF, 1, 0);
    u1_case("ded_b53", 16'hFFD7, 16'h87FC, 0, 1);

    for (int r = 0; r < 3; r++) begin
      prep15();
      run15(0, 1'b0, 66, first, second, nacks, nwr);
      check($sformatf("full%0d_ack_cycle", r), first, 61);
      check($sformatf("full%0d_ack_count", r), nacks, 1);
      check($sformatf("full%0d_wr_cycles", r), nwr, 30);
      check($sformatf("full%0d_sec", r), sec15, exp_sec);
      check($sformatf("full%0d_ded", r), ded15, exp_ded);
      check_words15($sformatf("full%0d", r));
    end

    // Reset during cycle 20 (word 4 high-byte write).
    prep15();
    @(negedge clk) req15 = 1'b1;
    @(posedge clk) #1;
    req15 = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clk) #1;
      cyc++;
    end
    reset = 1'b0;
    #1;
    check("midrst_ack", ack15, 0);
    check("midrst_busy", busy15, 0);
    check("midrst_wr_en", we15, 0);
    check("midrst_sec", sec15, 0);
    check("midrst_ded", ded15, 0);
    wl = 0;
    repeat (5) begin
      @(posedge clk) #1;
      if (we15) wl++;
    end
    check("midrst_writes_low", wl, 0);
    @(negedge clk) reset = 1'b1;
    check("midrst_w4_lo_written", mem15[102], exp_res[4][7:0]);
    check("midrst_w4_hi_blocked", mem15[103], 8'hAA);
    run15(0, 1'b0, 66, first, second, nacks, nwr);
    check("rerun_ack_cycle", first, 61);
    check("rerun_wr_cycles", nwr, 30);
    check("rerun_sec", sec15, exp_sec);
    check("rerun_ded", ded15, exp_ded);
    check_words15("rerun");

    // Second req pulse at cycle 10 is ignored.
    prep15();
    run15(10, 1'b0, 80, first, second, nacks, nwr);
    check("busyreq_ack_cycle", first, 61);
    check("busyreq_ack_count", nacks, 1);
    check("busyreq_wr_cycles", nwr, 30);
    check_words15("busyreq");

    // req held across DONE starts a second run on return to IDLE.
    prep15();
    run15(0, 1'b1, 130, first, second, nacks, nwr);
    check("hold_ack1_cycle", first, 61);
    check("hold_ack2_cycle", second, 123);
    check("hold_ack_count", nacks, 2);
    check("hold_wr_cycles", nwr, 60);
    check("hold_sec", sec15, exp_sec);
    check("hold_ded", ded15, exp_ded);
    check_words15("hold");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
